// File: rtl/native_bus_master_pkg.sv
// native_bus_master_pkg: shared state encoding and default width for the native bus master slice
package native_bus_master_pkg;
  localparam int def_bus_width = 32;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} state_e;
endpackage

// File: rtl/native_bus_master_if.sv
// native_bus_master_if: requester command/response and native memory channels of native_bus_master
interface native_bus_master_if
  import native_bus_master_pkg::*;
#(
  parameter int bus_width = def_bus_width
);
  logic req_valid, req_ready, req_write;
  logic [bus_width-1:0] req_addr, req_wdata;
  logic resp_valid, resp_error;
  logic [bus_width-1:0] resp_rdata;
  logic raddr_valid, raddr_ready, rdata_valid, rdata_ready;
  logic [bus_width-1:0] raddr, rdata;
  logic waddr_valid, waddr_ready, wdata_valid, wdata_ready;
  logic [bus_width-1:0] waddr, wdata;
  modport master (
    input req_valid, req_write, req_addr, req_wdata,
    input raddr_ready, rdata_valid, rdata, waddr_ready, wdata_ready,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output raddr_valid, raddr, rdata_ready, waddr_valid, waddr, wdata_valid, wdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output raddr_ready, rdata_valid, rdata, waddr_ready, wdata_ready,
    input req_ready, resp_valid, resp_rdata, resp_error,
    input raddr_valid, raddr, rdata_ready, waddr_valid, waddr, wdata_valid, wdata
  );
endinterface

// File: rtl/native_timeout_counter.sv
// native_timeout_counter: saturating stall counter; only built with NATIVE_BUS_MASTER_TIMEOUT_EN
`ifdef NATIVE_BUS_MASTER_TIMEOUT_EN
module native_timeout_counter #(
  parameter int timeout_cycles = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int cw = $clog2(timeout_cycles);
  logic [cw-1:0] cnt;
  // expired in the timeout_cycles-th enabled cycle; the count then holds there
  assign expired = enable && cnt == cw'(timeout_cycles - 1);
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
endmodule
`endif

// File: rtl/native_bus_master.sv
// native_bus_master: single-outstanding native bus initiator turning core requests into read/write handshakes.
// Define NATIVE_BUS_MASTER_TIMEOUT_EN to abort stalled transactions after timeout_cycles with resp_error.
module native_bus_master
  import native_bus_master_pkg::*;
#(
  parameter int bus_width = def_bus_width,
  parameter int timeout_cycles = 1024
) (
  input logic clk,
  input logic rst,
  native_bus_master_if.master bus
);
  state_e state, state_nxt;
  logic [bus_width-1:0] addr_q, wdata_q, rdata_q;
  logic aw_done, w_done, accept, aw_fire, w_fire, wr_done, busy, expired;
  if (timeout_cycles < 2) begin : g_bad_timeout
    $error("timeout_cycles must be at least 2");
  end
  assign accept = state == IDLE && bus.req_valid;
  assign busy = state == RD_ADDR || state == RD_DATA || state == WR;
  assign aw_fire = bus.waddr_valid && bus.waddr_ready;
  assign w_fire = bus.wdata_valid && bus.wdata_ready;
  assign wr_done = (aw_done || aw_fire) && (w_done || w_fire);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    if (busy && expired) state_nxt = RESP;
    else
      case (state)
        IDLE:    state_nxt = accept ? (bus.req_write ? WR : RD_ADDR) : IDLE;
        RD_ADDR: state_nxt = bus.raddr_ready ? RD_DATA : RD_ADDR;
        RD_DATA: state_nxt = bus.rdata_valid ? RESP : RD_DATA;
        WR:      state_nxt = wr_done ? RESP : WR;
        default: state_nxt = IDLE;
      endcase
  end
  // per-channel done flags let waddr and wdata retire independently
  always_ff @(posedge clk)
    if (rst) begin
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      aw_done <= accept ? 1'b0 : aw_done || aw_fire;
      w_done <= accept ? 1'b0 : w_done || w_fire;
      if (busy && expired) rdata_q <= '0;
      else if (state == RD_DATA && bus.rdata_valid) rdata_q <= bus.rdata;
    end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.raddr_valid = state == RD_ADDR;
    bus.rdata_ready = state == RD_DATA;
    bus.waddr_valid = state == WR && !aw_done;
    bus.wdata_valid = state == WR && !w_done;
    bus.resp_valid = state == RESP;
  end
  assign bus.raddr = addr_q;
  assign bus.waddr = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.resp_rdata = rdata_q;
`ifdef NATIVE_BUS_MASTER_TIMEOUT_EN
  logic err_q;
  native_timeout_counter #(.timeout_cycles(timeout_cycles)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clear(state == IDLE),
    .enable(busy),
    .expired(expired)
  );
  always_ff @(posedge clk)
    err_q <= rst || accept ? 1'b0 : err_q || (busy && expired);
  assign bus.resp_error = state == RESP && err_q;
`else
  assign expired = 1'b0;
  assign bus.resp_error = 1'b0;
`endif
endmodule

// File: tb/tb_native_bus_master.sv
// tb_native_bus_master: vector table plus reset/timeout sequences against a delay-programmable responder
module tb_native_bus_master;
  import native_bus_master_pkg::*;
  localparam int tmo = 8;
  typedef struct {
    logic wr;
    logic [31:0] addr, data, exp_rd;
    int ar_d, r_d, aw_d, w_d;
    bit hold, b2b, err;
  } vec_t;
  typedef struct {
    logic wr;
    logic [31:0] rdata;
    logic err;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int n_checks = 0, n_fail = 0, cyc = 0, prev_resp_cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  native_bus_master_if #(.bus_width(32)) bus ();
  native_bus_master #(.bus_width(32), .timeout_cycles(tmo)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  // responder: readies/data driven at negedge, each channel delayed by its *_dly cycles
  logic [31:0] mem [0:63];
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0;
  int ar_cnt, r_cnt, aw_cnt, w_cnt;
  bit rd_pend, aw_got, w_got;
  logic [31:0] rd_addr, wr_addr, wr_data;
  always @(negedge clk) begin
    if (rst) begin
      rd_pend = 0; aw_got = 0; w_got = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
      bus.raddr_ready = 0; bus.rdata_valid = 0; bus.rdata = '0;
      bus.waddr_ready = 0; bus.wdata_ready = 0;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[4] = 32'hDEADBEEF;
    end else begin
      bus.rdata_valid = rd_pend && r_cnt >= r_dly;
      bus.rdata = bus.rdata_valid ? mem[rd_addr[7:2]] : '0;
      if (bus.rdata_valid && bus.rdata_ready) rd_pend = 0;
      else if (rd_pend) r_cnt++;
      bus.raddr_ready = bus.raddr_valid && ar_cnt >= ar_dly;
      if (bus.raddr_ready) begin
        rd_pend = 1; rd_addr = bus.raddr; r_cnt = 0; ar_cnt = 0;
      end else ar_cnt = bus.raddr_valid ? ar_cnt + 1 : 0;
      bus.waddr_ready = bus.waddr_valid && aw_cnt >= aw_dly;
      if (bus.waddr_ready) begin
        aw_got = 1; wr_addr = bus.waddr; aw_cnt = 0;
      end else aw_cnt = bus.waddr_valid ? aw_cnt + 1 : 0;
      bus.wdata_ready = bus.wdata_valid && w_cnt >= w_dly;
      if (bus.wdata_ready) begin
        w_got = 1; wr_data = bus.wdata; w_cnt = 0;
      end else w_cnt = bus.wdata_valid ? w_cnt + 1 : 0;
      if (aw_got && w_got) begin
        mem[wr_addr[7:2]] = wr_data; aw_got = 0; w_got = 0;
      end
    end
  end
  // scoreboard: expectations pushed at acceptance, popped on each resp_valid
  exp_t exp_q[$];
  always @(negedge clk)
    if (!rst && bus.resp_valid) begin : mon
      exp_t e;
      chk("resp_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (!e.wr) chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_error", bus.resp_error, e.err);
      end
    end
  task automatic run_vec(input vec_t v);
    int lat, k, exp_lat, arc, rrc, awc, wc;
    bit unstable, rdy_busy;
    exp_t e;
    k = 0; arc = 0; rrc = 0; awc = 0; wc = 0; unstable = 0; rdy_busy = 0;
    exp_lat = v.err ? tmo + 1 : v.wr ? 2 + (v.aw_d > v.w_d ? v.aw_d : v.w_d) : 3 + v.ar_d + v.r_d;
    ar_dly = v.ar_d; r_dly = v.r_d; aw_dly = v.aw_d; w_dly = v.w_d;
    @(negedge clk);
    bus.req_valid = 1; bus.req_write = v.wr; bus.req_addr = v.addr; bus.req_wdata = v.data;
    while (!bus.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("req_accept_wait", 64'(k < 50), 1);
    @(posedge clk);
    e.wr = v.wr; e.rdata = v.exp_rd; e.err = v.err;
    exp_q.push_back(e);
    #1;
    if (v.b2b) chk("b2b_accept_cycle", 64'(cyc), 64'(prev_resp_cyc + 2));
    if (!v.hold) bus.req_valid = 0;
    lat = 1;
    while (!bus.resp_valid && lat < 300) begin
      arc += int'(bus.raddr_valid); rrc += int'(bus.rdata_ready);
      awc += int'(bus.waddr_valid); wc += int'(bus.wdata_valid);
      if (bus.req_ready) rdy_busy = 1;
      if ((bus.raddr_valid && bus.raddr != v.addr) || (bus.waddr_valid && bus.waddr != v.addr) ||
          (bus.wdata_valid && bus.wdata != v.data)) unstable = 1;
      @(posedge clk);
      #1;
      lat++;
    end
    prev_resp_cyc = cyc;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("raddr_valid_cycles", 64'(arc), 64'(v.wr ? 0 : v.err ? tmo : 1 + v.ar_d));
    chk("rdata_ready_cycles", 64'(rrc), 64'(v.wr || v.err ? 0 : 1 + v.r_d));
    chk("waddr_valid_cycles", 64'(awc), 64'(v.wr ? 1 + v.aw_d : 0));
    chk("wdata_valid_cycles", 64'(wc), 64'(v.wr ? 1 + v.w_d : 0));
    chk("addr_data_stable", 64'(unstable), 0);
    chk("req_ready_low_busy", 64'(rdy_busy), 0);
    @(posedge clk);
    #1;
    chk("resp_single_pulse", bus.resp_valid, 0);
    if (v.wr) chk("mem_word", mem[v.addr[7:2]], v.data);
  endtask
  vec_t vecs[$];
  initial begin
    int k, n;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
    vecs.push_back('{wr:0, addr:32'h10, data:0, exp_rd:32'hDEADBEEF, ar_d:0, r_d:0, aw_d:0, w_d:0, hold:0, b2b:0, err:0});
    vecs.push_back('{wr:1, addr:32'h20, data:32'hCAFEF00D, exp_rd:0, ar_d:0, r_d:0, aw_d:2, w_d:0, hold:0, b2b:0, err:0});
    vecs.push_back('{wr:1, addr:32'h04, data:32'h55AA55AA, exp_rd:0, ar_d:0, r_d:0, aw_d:0, w_d:0, hold:1, b2b:0, err:0});
    vecs.push_back('{wr:0, addr:32'h04, data:0, exp_rd:32'h55AA55AA, ar_d:0, r_d:0, aw_d:0, w_d:0, hold:0, b2b:1, err:0});
    vecs.push_back('{wr:0, addr:32'h20, data:0, exp_rd:32'hCAFEF00D, ar_d:0, r_d:5, aw_d:0, w_d:0, hold:0, b2b:0, err:0});
    vecs.push_back('{wr:1, addr:32'h08, data:32'h12345678, exp_rd:0, ar_d:0, r_d:0, aw_d:0, w_d:3, hold:0, b2b:0, err:0});
    vecs.push_back('{wr:1, addr:32'h0C, data:32'hA5A5A5A5, exp_rd:0, ar_d:0, r_d:0, aw_d:1, w_d:1, hold:0, b2b:0, err:0});
    vecs.push_back('{wr:0, addr:32'h08, data:0, exp_rd:32'h12345678, ar_d:2, r_d:1, aw_d:0, w_d:0, hold:0, b2b:0, err:0});
    vecs.push_back('{wr:0, addr:32'h00, data:0, exp_rd:32'h0, ar_d:0, r_d:0, aw_d:0, w_d:0, hold:0, b2b:0, err:0});
`ifdef NATIVE_BUS_MASTER_TIMEOUT_EN
    vecs.push_back('{wr:0, addr:32'h10, data:0, exp_rd:32'h0, ar_d:1000, r_d:0, aw_d:0, w_d:0, hold:0, b2b:0, err:1});
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_handshake", {bus.req_ready, bus.raddr_valid, bus.rdata_ready, bus.waddr_valid,
                            bus.wdata_valid, bus.resp_valid, bus.resp_error}, 7'b1000000);
    chk("reset_raddr", bus.raddr, 0);
    chk("reset_waddr_wdata", {bus.waddr, bus.wdata}, 0);
    chk("reset_resp_rdata", bus.resp_rdata, 0);
    rst = 0;
    foreach (vecs[i]) run_vec(vecs[i]);
    // reset pulse while waiting in RD_DATA discards the read
    ar_dly = 0; r_dly = 50;
    @(negedge clk);
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h10;
    @(posedge clk);
    #1;
    bus.req_valid = 0;
    k = 0;
    while (!bus.rdata_ready && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reached_rd_data", bus.rdata_ready, 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("mid_rst_outputs", {bus.req_ready, bus.raddr_valid, bus.rdata_ready, bus.waddr_valid,
                            bus.wdata_valid, bus.resp_valid}, 6'b100000);
    n = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      n += int'(bus.resp_valid);
    end
    chk("no_resp_after_rst", 64'(n), 0);
    run_vec('{wr:0, addr:32'h10, data:0, exp_rd:32'hDEADBEEF, ar_d:0, r_d:0, aw_d:0, w_d:0, hold:0, b2b:0, err:0});
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
